// File: rtl/bcd_excess3_pkg.sv
// Shared types and constants for the BCD-to-Excess-3 converter.
package bcd_excess3_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t EXCESS3_OFFSET = 4'd3;
    localparam bcd_digit_t BCD_MAX        = 4'd9;

endpackage

// File: rtl/bcd_excess3_digit.sv
// Combinational single-digit BCD to Excess-3 conversion with invalid-digit flag.
module bcd_excess3_digit
    import bcd_excess3_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] code,
    output logic       invalid
);

    bcd_digit_t bcd_digit;

    assign bcd_digit = bcd;

    // Sum is kept to 4 bits so codes for 13..15 wrap to 0..2.
    assign code    = bcd_digit + EXCESS3_OFFSET;
    assign invalid = (bcd_digit > BCD_MAX);

endmodule

// File: rtl/bcd_excess3.sv
// Registered multi-digit BCD to Excess-3 converter with per-digit error flags.
// Optional BCD_EXCESS3_STICKY_ERR_EN makes err bits hold until reset.
module bcd_excess3
    import bcd_excess3_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   a,
    output logic [4*DIGITS-1:0]   y,
    output logic [DIGITS-1:0]     err
);

    logic [4*DIGITS-1:0] code_next;
    logic [DIGITS-1:0]   invalid_next;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_excess3_digit u_digit (
                .bcd     (a[4*k +: 4]),
                .code    (code_next[4*k +: 4]),
                .invalid (invalid_next[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y   <= '0;
            err <= '0;
        end else begin
            y <= code_next;
`ifdef BCD_EXCESS3_STICKY_ERR_EN
            err <= err | invalid_next;
`else
            err <= invalid_next;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_excess3.sv
// Directed self-checking bench for bcd_excess3 (one-digit and two-digit instances).
module tb_bcd_excess3;

    logic       clk;
    logic       rst_n;
    logic [3:0] a1;
    logic [3:0] y1;
    logic [0:0] err1;
    logic [7:0] a2;
    logic [7:0] y2;
    logic [1:0] err2;

    int checks;
    int errors;

    bcd_excess3 #(.DIGITS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .y     (y1),
        .err   (err1)
    );

    bcd_excess3 #(.DIGITS(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a2),
        .y     (y2),
        .err   (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after one rising edge.
    task automatic applyStimulus(input logic [3:0] v1, input logic [7:0] v2);
        a1 = v1;
        a2 = v2;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] sweep_y [16];

    initial begin
        sweep_y = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                    4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a1     = 4'h7;
        a2     = 8'h00;

        // Reset held while clock toggles with valid input present.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_y", 32'(y1), 32'h0);
            checkOutput("reset_err", 32'(err1), 32'h0);
        end
        rst_n = 1'b1;
        applyStimulus(4'h7, 8'h00);
        checkOutput("release_y", 32'(y1), 32'hA);
        checkOutput("release_err", 32'(err1), 32'h0);

        // Full nibble sweep including invalid codes.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i), 8'h00);
            checkOutput($sformatf("sweep_y_%0d", i), 32'(y1), 32'(sweep_y[i]));
            checkOutput($sformatf("sweep_err_%0d", i), 32'(err1), (i > 9) ? 32'h1 : 32'h0);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Valid-to-invalid boundary on successive edges.
        applyStimulus(4'd9, 8'h00);
        checkOutput("b9_y", 32'(y1), 32'hC);
        checkOutput("b9_err", 32'(err1), 32'h0);
        applyStimulus(4'd10, 8'h00);
        checkOutput("b10_y", 32'(y1), 32'hD);
        checkOutput("b10_err", 32'(err1), 32'h1);

        // Asynchronous reset assertion between clock edges.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'd9, 8'h00);
        checkOutput("pre_async_y", 32'(y1), 32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_y", 32'(y1), 32'h0);
        checkOutput("async_err", 32'(err1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-digit instance: independent digits, no inter-digit carry.
        applyStimulus(4'd0, 8'h95);
        checkOutput("d2_95_y", 32'(y2), 32'hC8);
        checkOutput("d2_95_err", 32'(err2), 32'h0);
        applyStimulus(4'd0, 8'hF3);
        checkOutput("d2_F3_y", 32'(y2), 32'h26);
        checkOutput("d2_F3_err", 32'(err2), 32'h2);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Invalid digit followed by a valid one.
        applyStimulus(4'd12, 8'h00);
        checkOutput("inv12_y", 32'(y1), 32'hF);
        checkOutput("inv12_err", 32'(err1), 32'h1);
        applyStimulus(4'd2, 8'h00);
        checkOutput("after_inv_y", 32'(y1), 32'h5);
`ifdef BCD_EXCESS3_STICKY_ERR_EN
        checkOutput("after_inv_err", 32'(err1), 32'h1);
`else
        checkOutput("after_inv_err", 32'(err1), 32'h0);
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("pulse_err", 32'(err1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'd2, 8'h00);
        checkOutput("post_pulse_y", 32'(y1), 32'h5);
        checkOutput("post_pulse_err", 32'(err1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
